// File: rtl/pipelined_adder_pkg.sv
// ============================================================================
// Module      : adder_pkg
// Description : Shared defaults and configuration helpers for the pipelined
//               unsigned adder (slice width and split validity checks).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_pkg;

  localparam int DEF_WIDTH  = 8;
  localparam int DEF_SLICES = 2;

  // Bits handled by each pipeline stage.
  function automatic int slice_w(input int width, input int slices);
    return width / slices;
  endfunction

  // A split is usable only when every slice is a whole, non-empty bit range.
  function automatic bit split_ok(input int width, input int slices);
    return (slices >= 1) && (slices <= width) && ((width % slices) == 0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pipelined_adder_if.sv
// ============================================================================
// Module      : pipelined_adder_if
// Description : Operand/result valid-ready bundle for the pipelined adder.
//               The ovf signal exists only when PIPE_ADDER_OVF_EN is defined.
//               master = producer/consumer side, slave = adder side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipelined_adder_if
  import adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   sum;
`ifdef PIPE_ADDER_OVF_EN
  logic             ovf;
`endif

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum
`ifdef PIPE_ADDER_OVF_EN
    , input ovf
`endif
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum
`ifdef PIPE_ADDER_OVF_EN
    , output ovf
`endif
  );

endinterface

`default_nettype wire

// File: rtl/pipelined_adder_slice.sv
// ============================================================================
// Module      : adder_slice
// Description : One carry-ripple stage: SW-bit add with carry-in, result and
//               carry-out registered, holding while en is low.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_slice
  import adder_pkg::*;
#(
  parameter int SW = 4
) (
  input  wire logic          clk,
  input  wire logic          rst_n,
  input  wire logic          en,
  input  wire logic [SW-1:0] a,
  input  wire logic [SW-1:0] b,
  input  wire logic          ci,
  output logic      [SW-1:0] s,
  output logic               co
);

  logic [SW:0] total;

  assign total = {1'b0, a} + {1'b0, b} + {{SW{1'b0}}, ci};

  // Stage register: capture partial sum and carry when the pipe advances.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s  <= '0;
      co <= 1'b0;
    end else if (en) begin
      s  <= total[SW-1:0];
      co <= total[SW];
    end
  end

endmodule

`default_nettype wire

// File: rtl/pipelined_adder.sv
// ============================================================================
// Module      : pipelined_adder
// Description : Parametrised pipelined unsigned adder. The carry ripples one
//               slice per clock; upper operand slices are skewed in and lower
//               partial sums are deskewed out so the full result appears
//               SLICES cycles after acceptance. Valid/ready on both sides with
//               a single global advance for back-pressure.
//               Optional feature macro: PIPE_ADDER_OVF_EN (signed overflow).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int SLICES = DEF_SLICES
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  pipelined_adder_if.slave bus
);

  localparam int SW = slice_w(WIDTH, SLICES);

  if (!split_ok(WIDTH, SLICES)) begin : g_bad_cfg
    $error("pipelined_adder: WIDTH must be a non-zero multiple of SLICES (1..WIDTH)");
  end

  logic              advance;
  logic              in_fire;
  logic [SLICES-1:0] vld;
  logic [SW-1:0]     op_a [SLICES];
  logic [SW-1:0]     op_b [SLICES];
  logic [SW-1:0]     ps   [SLICES];
  logic              co   [SLICES];
  logic [WIDTH-1:0]  low;

  // The whole pipe moves together; it stalls only when a result is waiting.
  assign advance       = bus.out_ready | ~bus.out_valid;
  assign in_fire       = bus.in_valid & advance;
  assign bus.in_ready  = advance;
  assign bus.out_valid = vld[SLICES-1];
  assign bus.sum       = {co[SLICES-1], low};

  // Valid token shift: bubbles travel alongside data and are not collapsed.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld <= '0;
    end else if (advance) begin
      vld[0] <= in_fire;
      for (int i = 1; i < SLICES; i++) begin
        vld[i] <= vld[i-1];
      end
    end
  end

  for (genvar k = 0; k < SLICES; k++) begin : g_stage
    localparam int DESKEW = SLICES - 1 - k;
    logic ci;

    if (k == 0) begin : g_noskew
      assign op_a[k] = bus.a[SW-1:0];
      assign op_b[k] = bus.b[SW-1:0];
      assign ci      = bus.cin;
    end else begin : g_skew
      logic [SW-1:0] qa [k];
      logic [SW-1:0] qb [k];

      // Input skew: slice k waits k cycles for the carry to reach it.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int d = 0; d < k; d++) begin
            qa[d] <= '0;
            qb[d] <= '0;
          end
        end else if (advance) begin
          qa[0] <= bus.a[k*SW +: SW];
          qb[0] <= bus.b[k*SW +: SW];
          for (int d = 1; d < k; d++) begin
            qa[d] <= qa[d-1];
            qb[d] <= qb[d-1];
          end
        end
      end

      assign op_a[k] = qa[k-1];
      assign op_b[k] = qb[k-1];
      assign ci      = co[k-1];
    end

    adder_slice #(.SW(SW)) u_slice (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (advance),
      .a     (op_a[k]),
      .b     (op_b[k]),
      .ci    (ci),
      .s     (ps[k]),
      .co    (co[k])
    );

    if (DESKEW == 0) begin : g_nodeskew
      assign low[k*SW +: SW] = ps[k];
    end else begin : g_deskew
      logic [SW-1:0] dq [DESKEW];

      // Output deskew: hold early partial sums until the top slice finishes.
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int d = 0; d < DESKEW; d++) begin
            dq[d] <= '0;
          end
        end else if (advance) begin
          dq[0] <= ps[k];
          for (int d = 1; d < DESKEW; d++) begin
            dq[d] <= dq[d-1];
          end
        end
      end

      assign low[k*SW +: SW] = dq[DESKEW-1];
    end
  end

`ifdef PIPE_ADDER_OVF_EN
  logic sign_a;
  logic sign_b;

  // Operand sign bits captured alongside the top slice so the flag lines up
  // with the registered result MSB; it only changes at the stage edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sign_a <= 1'b0;
      sign_b <= 1'b0;
    end else if (advance) begin
      sign_a <= op_a[SLICES-1][SW-1];
      sign_b <= op_b[SLICES-1][SW-1];
    end
  end

  assign bus.ovf = (sign_a == sign_b) & (ps[SLICES-1][SW-1] != sign_a);
`endif

endmodule

`default_nettype wire

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined unsigned adder; successor to the fixed 4-bit combinational adder.
- Operand width is split into equal slices. Carry ripples one slice per clock through registered stages, with input-skew and output-deskew registers.
- Valid/ready handshake on both sides with full back-pressure. Sits between operand-producing datapath blocks and result consumers.

Parameters:
- WIDTH, 8, operand width in bits; must be a multiple of SLICES.
- SLICES, 2, number of pipeline slices; also the latency in cycles. Range 1..WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands a, b, cin are valid this cycle.
- in_ready  output  1  adder accepts operands this cycle.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in.
- out_valid  output  1  sum is valid.
- out_ready  input  1  consumer accepts sum.
- sum  output  WIDTH+1  a+b+cin; MSB is carry-out.
- ovf  output  1  signed overflow flag; present only with PIPE_ADDER_OVF_EN.

Behaviour:
- Single clock domain. One clock; reset is synchronous and active-low.
- Reset (rst_n=0 at a clk edge): all stage valid bits cleared, out_valid=0, sum=0, ovf=0. in_ready=1 once out_valid=0.
- Reset mid-operation discards all in-flight data; no partial result is ever presented.
- Slice width SW = WIDTH/SLICES.
- Stage k adds slice k of a and b plus the carry from stage k-1 (stage 0 uses cin). It registers the SW-bit partial sum and the carry.
- Higher slices of the operands are delayed by k registers (input skew). Lower partial sums are delayed to align (output deskew).
- Global advance: advance = out_ready | ~out_valid. When advance=0, every stage register holds.
- in_ready = advance (combinational from out_ready and out_valid). A transfer occurs when in_valid & in_ready.
- Latency: a transfer at edge N produces out_valid=1 after edge N+SLICES-1, visible in the cycle following that edge. Back-to-back throughput is 1 result per cycle.
- Bubbles (in_valid=0) propagate as valid=0 and are not collapsed.
- out_valid and sum are stable while out_valid & ~out_ready.
- Result is exact: sum = a+b+cin, modulo 2^(WIDTH+1); it never truncates. Example: 0xFF+0xFF+1 = 0x1FF.
- SLICES=1 degenerates to a single registered adder with latency 1.
- Simultaneous output transfer and input transfer in the same cycle is legal; the pipeline shifts by one.

Optional Feature:
- Macro: PIPE_ADDER_OVF_EN.
- Defined: port ovf exists, aligned with sum. ovf=1 when a and b interpreted as two's-complement WIDTH-bit values overflow, i.e. sign(a)==sign(b) and sign(result[WIDTH-1])!=sign(a). Computed in the last slice and registered with it.
- Undefined: ovf port and its logic are absent. All other behaviour is unchanged.

Decomposition:
- Package adder_pkg holds:
  - localparam defaults DEF_WIDTH=8 and DEF_SLICES=2.
  - A function slice_w(width, slices).
  - A compile-time check that WIDTH % SLICES == 0, reported as an elaboration error.
- Sub-module adder_slice: parametrised SW-bit adder with carry-in and carry-out, plus the stage register and a hold enable.
  - Instantiated SLICES times in a generate loop.
  - Skew/deskew registers live in the top module.

Test Plan (WIDTH=8, SLICES=2 unless noted):
- Carry across slice boundary: a=0x0F, b=0x01, cin=0, out_ready=1 -> 2 cycles later out_valid=1, sum=0x010. Then a=0xFF, b=0x01 -> sum=0x100.
- Max operands: a=0xFF, b=0xFF, cin=1 -> sum=0x1FF. With PIPE_ADDER_OVF_EN: a=0x7F, b=0x01 -> sum=0x080, ovf=1; a=0x80, b=0xFF -> sum=0x17F, ovf=1; a=0x10, b=0x20 -> ovf=0.
- Throughput: 16 consecutive random a/b with in_valid=1, out_ready=1 -> 16 consecutive out_valid cycles. Each sum matches the reference model (a+b+cin), in order.
- Back-pressure: stream 5 operands, drop out_ready for 3 cycles -> in_ready=0 during the stall, sum and out_valid held. After release, no loss or duplication; all 5 sums appear in order.
- Reset mid-flight: issue 2 operands, assert rst_n=0 for 1 cycle before either emerges -> out_valid stays 0 and in_ready=1 after reset. Next operand pair 0x03+0x04 -> sum=0x007 after 2 cycles.
- Parameter sweep: WIDTH=32 with SLICES=1, 4, 8 -> latency equals SLICES. Random stimulus matches the model over 1000 transactions.
